// File: rtl/fft16_pkg.sv
// Shared types, sizes and the bank-mapping helper for the 16-point FFT sequencer.
package fft16_pkg;

    localparam int N_POINTS = 16;
    localparam int N_STAGES = 4;
    localparam int TWID_AW  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARRANGE = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } fft16_state_t;

    // Swizzle bit 3 into bit 0 so the two operands of every butterfly land in different banks
    function automatic logic [2:0] bank_of(input logic [3:0] n);
        return n[2:0] ^ {2'b00, n[3]};
    endfunction

endpackage

// File: rtl/fft16_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly) -> operand indexes,
// twiddle exponent, banks and row of the a operand.
module fft16_addr_gen
    import fft16_pkg::*;
(
    input  logic [1:0]         stage,
    input  logic [2:0]         bfly,
    output logic [3:0]         idx_a,
    output logic [3:0]         idx_b,
    output logic [TWID_AW-1:0] twid,
    output logic [2:0]         bank_a,
    output logic [2:0]         bank_b,
    output logic               row_a
);

    logic [3:0] span_s;

    // Insert a zero at bit position 'stage' of the butterfly number to form the a index
    always_comb begin
        idx_a  = 4'd0;
        twid   = 3'd0;
        span_s = 4'd1 << stage;
        case (stage)
            2'd0: begin
                idx_a = {bfly, 1'b0};
                twid  = 3'd0;
            end
            2'd1: begin
                idx_a = {bfly[2:1], 1'b0, bfly[0]};
                twid  = {bfly[0], 2'b00};
            end
            2'd2: begin
                idx_a = {bfly[2], 1'b0, bfly[1:0]};
                twid  = {bfly[1:0], 1'b0};
            end
            2'd3: begin
                idx_a = {1'b0, bfly};
                twid  = bfly;
            end
            default: begin
                idx_a = 4'd0;
                twid  = 3'd0;
            end
        endcase
        idx_b  = idx_a + span_s;
        bank_a = bank_of(idx_a);
        bank_b = bank_of(idx_b);
        row_a  = idx_a[3];
    end

endmodule

// File: rtl/ctrl_fft16.sv
// Sequencer for the 16-point radix-2 DIT FFT datapath: arrange step, then
// 4 stages x 8 butterflies at one butterfly per cycle, all outputs registered.
module ctrl_fft16
    import fft16_pkg::*;
(
    input  logic       i_clk_ctrl_fft16,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_done_arrange,
    output logic       o_en_arrg,
    output logic       o_mem_initial,
    output logic [5:0] o_a_rd_index,
    output logic [5:0] o_b_rd_index,
    output logic       o_rd_add,
    output logic [2:0] o_a_wr_index,
    output logic [2:0] o_b_wr_index,
    output logic       o_wr_add,
    output logic       o_wr_en,
    output logic [2:0] o_add_twid_rom,
    output logic [1:0] o_num_stage3,
    output logic       o_done_stage3,
    output logic       o_rst_serpar4,
    output logic       o_busy,
    output logic       o_done
);

    fft16_state_t state_q, state_d;
    logic [2:0]   bfly_q, bfly_d;
    logic [1:0]   stage_q, stage_d;

    logic         en_arrg_d, mem_initial_d, rd_add_d, wr_add_d, wr_en_d;
    logic [5:0]   a_rd_index_d, b_rd_index_d;
    logic [2:0]   a_wr_index_d, b_wr_index_d, add_twid_rom_d;
    logic [1:0]   num_stage3_d;
    logic         done_stage3_d, rst_serpar4_d, busy_d, done_d;

    logic [3:0]   idx_a_s, idx_b_s;
    logic [2:0]   twid_s, bank_a_s, bank_b_s;
    logic         row_a_s;

    fft16_addr_gen u_addr_gen (
        .stage  (stage_q),
        .bfly   (bfly_q),
        .idx_a  (idx_a_s),
        .idx_b  (idx_b_s),
        .twid   (twid_s),
        .bank_a (bank_a_s),
        .bank_b (bank_b_s),
        .row_a  (row_a_s)
    );

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        bfly_d  = bfly_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                bfly_d  = 3'd0;
                stage_d = 2'd0;
                if (i_start) begin
                    state_d = ARRANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            ARRANGE: begin
                if (i_done_arrange) begin
                    state_d = RUN;
                end else begin
                    state_d = ARRANGE;
                end
            end
            RUN: begin
                bfly_d = bfly_q + 3'd1;
                if (bfly_q == 3'd7) begin
                    stage_d = stage_q + 2'd1;
                    if (stage_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    stage_d = stage_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                bfly_d  = 3'd0;
                stage_d = 2'd0;
            end
        endcase
    end

    // Output decode; the registers below present it one cycle later as a coherent set
    always_comb begin
        en_arrg_d      = 1'b0;
        mem_initial_d  = 1'b0;
        a_rd_index_d   = 6'd0;
        b_rd_index_d   = 6'd0;
        rd_add_d       = 1'b0;
        a_wr_index_d   = 3'd0;
        b_wr_index_d   = 3'd0;
        wr_add_d       = 1'b0;
        wr_en_d        = 1'b0;
        add_twid_rom_d = 3'd0;
        num_stage3_d   = 2'd0;
        done_stage3_d  = 1'b0;
        rst_serpar4_d  = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
            end
            ARRANGE: begin
                en_arrg_d = 1'b1;
                busy_d    = 1'b1;
            end
            RUN: begin
                busy_d         = 1'b1;
                num_stage3_d   = stage_q;
                add_twid_rom_d = twid_s;
                done_stage3_d  = (stage_q == 2'd2) && (bfly_q == 3'd7);
                if (stage_q == 2'd0) begin
                    mem_initial_d = 1'b1;
                    a_rd_index_d  = {2'b00, idx_a_s};
                    b_rd_index_d  = {2'b00, idx_b_s};
                end else begin
                    a_rd_index_d  = {3'b000, bank_a_s};
                    b_rd_index_d  = {3'b000, bank_b_s};
                    rd_add_d      = row_a_s;
                end
                // Last stage streams into ser_par instead of writing the banks back
                if (stage_q == 2'd3) begin
                    rst_serpar4_d = 1'b1;
                end else begin
                    wr_en_d      = 1'b1;
                    a_wr_index_d = bank_a_s;
                    b_wr_index_d = bank_b_s;
                    wr_add_d     = row_a_s;
                end
            end
            DONE: begin
                busy_d        = 1'b1;
                done_d        = 1'b1;
                rst_serpar4_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge i_clk_ctrl_fft16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bfly_q  <= 3'd0;
            stage_q <= 2'd0;
        end else begin
            state_q <= state_d;
            bfly_q  <= bfly_d;
            stage_q <= stage_d;
        end
    end

    // Output registers
    always_ff @(posedge i_clk_ctrl_fft16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_en_arrg      <= 1'b0;
            o_mem_initial  <= 1'b0;
            o_a_rd_index   <= 6'd0;
            o_b_rd_index   <= 6'd0;
            o_rd_add       <= 1'b0;
            o_a_wr_index   <= 3'd0;
            o_b_wr_index   <= 3'd0;
            o_wr_add       <= 1'b0;
            o_wr_en        <= 1'b0;
            o_add_twid_rom <= 3'd0;
            o_num_stage3   <= 2'd0;
            o_done_stage3  <= 1'b0;
            o_rst_serpar4  <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_en_arrg      <= en_arrg_d;
            o_mem_initial  <= mem_initial_d;
            o_a_rd_index   <= a_rd_index_d;
            o_b_rd_index   <= b_rd_index_d;
            o_rd_add       <= rd_add_d;
            o_a_wr_index   <= a_wr_index_d;
            o_b_wr_index   <= b_wr_index_d;
            o_wr_add       <= wr_add_d;
            o_wr_en        <= wr_en_d;
            o_add_twid_rom <= add_twid_rom_d;
            o_num_stage3   <= num_stage3_d;
            o_done_stage3  <= done_stage3_d;
            o_rst_serpar4  <= rst_serpar4_d;
            o_busy         <= busy_d;
            o_done         <= done_d;
        end
    end

endmodule

// File: tb/tb_ctrl_fft16.sv
// Directed self-checking bench for ctrl_fft16: idle/reset state, full runs with
// per-butterfly index checks, mid-run reset, start-while-busy and start held in DONE.
module tb_ctrl_fft16;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       done_arrange;
    logic       en_arrg, mem_initial, rd_add, wr_add, wr_en;
    logic [5:0] a_rd, b_rd;
    logic [2:0] a_wr, b_wr, twid;
    logic [1:0] num_stage;
    logic       done_stage3, rst_serpar4, busy, done;

    int checks = 0;
    int errors = 0;

    ctrl_fft16 dut (
        .i_clk_ctrl_fft16 (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_done_arrange   (done_arrange),
        .o_en_arrg        (en_arrg),
        .o_mem_initial    (mem_initial),
        .o_a_rd_index     (a_rd),
        .o_b_rd_index     (b_rd),
        .o_rd_add         (rd_add),
        .o_a_wr_index     (a_wr),
        .o_b_wr_index     (b_wr),
        .o_wr_add         (wr_add),
        .o_wr_en          (wr_en),
        .o_add_twid_rom   (twid),
        .o_num_stage3     (num_stage),
        .o_done_stage3    (done_stage3),
        .o_rst_serpar4    (rst_serpar4),
        .o_busy           (busy),
        .o_done           (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".en_arrg"}, en_arrg, 0);
        chk({tag, ".mem_initial"}, mem_initial, 0);
        chk({tag, ".a_rd"}, a_rd, 0);
        chk({tag, ".b_rd"}, b_rd, 0);
        chk({tag, ".rd_add"}, rd_add, 0);
        chk({tag, ".a_wr"}, a_wr, 0);
        chk({tag, ".b_wr"}, b_wr, 0);
        chk({tag, ".wr_add"}, wr_add, 0);
        chk({tag, ".wr_en"}, wr_en, 0);
        chk({tag, ".twid"}, twid, 0);
        chk({tag, ".num_stage"}, num_stage, 0);
        chk({tag, ".done_stage3"}, done_stage3, 0);
        chk({tag, ".rst_serpar4"}, rst_serpar4, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    // One FFT run; abort_j >= 0 pulls reset right after butterfly abort_j is checked
    task automatic run_fft(input int abort_j, input bit spurious, input bit hold);
        int s, k, span, a, b, tw, ba, bb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arr_busy_lag", busy, 0);
        tick();
        chk("arr_en", en_arrg, 1);
        chk("arr_busy", busy, 1);
        done_arrange = 1'b1;
        tick();
        done_arrange = 1'b0;
        chk("arr_en2", en_arrg, 1);
        chk("arr_wr_en", wr_en, 0);
        for (int j = 0; j < 32; j++) begin
            if (spurious && j == 10) start = 1'b1;
            if (spurious && j == 12) start = 1'b0;
            tick();
            s    = j / 8;
            k    = j % 8;
            span = 1 << s;
            a    = ((k >> s) << (s + 1)) | (k & (span - 1));
            b    = a + span;
            tw   = ((k & (span - 1)) << (3 - s)) & 7;
            ba   = (a & 7) ^ (a >> 3);
            bb   = (b & 7) ^ (b >> 3);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_en_arrg", en_arrg, 0);
            chk("run_stage", num_stage, s);
            chk("run_mem_initial", mem_initial, (s == 0) ? 1 : 0);
            chk("run_a_rd", a_rd, (s == 0) ? a : ba);
            chk("run_b_rd", b_rd, (s == 0) ? b : bb);
            chk("run_rd_add", rd_add, (s == 0) ? 0 : ((a >> 3) & 1));
            chk("run_wr_en", wr_en, (s == 3) ? 0 : 1);
            chk("run_a_wr", a_wr, (s == 3) ? 0 : ba);
            chk("run_b_wr", b_wr, (s == 3) ? 0 : bb);
            chk("run_wr_add", wr_add, (s == 3) ? 0 : ((a >> 3) & 1));
            chk("run_twid", twid, tw);
            chk("run_done_stage3", done_stage3, (s == 2 && k == 7) ? 1 : 0);
            chk("run_rst_serpar4", rst_serpar4, (s == 3) ? 1 : 0);
            if (s == 1 && k == 3) begin
                chk("s1k3_a_wr", a_wr, 5);
                chk("s1k3_b_wr", b_wr, 7);
                chk("s1k3_twid", twid, 4);
                chk("s1k3_rd_add", rd_add, 0);
                chk("s1k3_wr_en", wr_en, 1);
            end
            if (s == 3 && k == 5) begin
                chk("s3k5_a_rd", a_rd, 5);
                chk("s3k5_b_rd", b_rd, 4);
                chk("s3k5_twid", twid, 5);
                chk("s3k5_wr_en", wr_en, 0);
                chk("s3k5_serpar", rst_serpar4, 1);
            end
            if (j == abort_j) begin
                rst_n = 1'b0;
                #1;
                check_idle("abort");
                #2;
                rst_n = 1'b1;
                return;
            end
        end
        if (hold) start = 1'b1;
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_wr_en", wr_en, 0);
        chk("done_serpar", rst_serpar4, 1);
        tick();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_serpar", rst_serpar4, 0);
        if (hold) begin
            start = 1'b0;
            tick();
            chk("restart_en_arrg", en_arrg, 1);
            chk("restart_busy", busy, 1);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        done_arrange = 1'b0;
        tick();
        tick();
        check_idle("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_idle("idle");

        run_fft(-1, 1'b0, 1'b0);
        tick();
        check_idle("after_run1");

        run_fft(19, 1'b0, 1'b0);
        tick();
        tick();
        check_idle("after_abort");

        run_fft(-1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
